ldm_stm_sequencer: RTL and testbench

- Multi-cycle sequencer for ARM LDM/STM block transfers.
- Sits directly upstream of RegisterFile. Drives its read address port 2 (store data) and its write port 3 (load data, base writeback). Also drives data-memory address and write strobes.
- Transfers one register per cycle, lowest-numbered register at lowest address, then optionally writes back the base register.

---
 rtl/arm_cpu_pkg.sv | 14 +
 rtl/ldm_stm_sequencer_if.sv | 46 ++++
 rtl/ldm_stm_sequencer_lowest_set_bit_encoder.sv | 21 ++
 rtl/ldm_stm_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_cpu_pkg.sv
// Shared CPU-side types and constants for the LDM/STM block-transfer sequencer.
package arm_cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRANSFER  = 2'd1,
    S_WRITEBACK = 2'd2,
    S_DONE      = 2'd3
  } ldm_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PC_INDEX   = 15;

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Command, RegisterFile and data-memory signals of the LDM/STM sequencer.
interface ldm_stm_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16
);
  localparam int unsigned IDX_W = $clog2(REG_COUNT);

  logic                  start;
  logic                  is_load;
  logic                  pre_index;
  logic                  up;
  logic                  writeback;
  logic [IDX_W-1:0]      base_reg;
  logic [DATA_WIDTH-1:0] base_value;
  logic [REG_COUNT-1:0]  register_list;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] mem_read_data;

  logic [IDX_W-1:0]      read_reg_addr2;
  logic                  write_enable3;
  logic [IDX_W-1:0]      write_reg_addr3;
  logic [DATA_WIDTH-1:0] write_data3;
  logic                  pc_write_enable;
  logic [DATA_WIDTH-1:0] pc_write_data;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, is_load, pre_index, up, writeback, base_reg, base_value,
           register_list, read_data2, mem_read_data,
    input  read_reg_addr2, write_enable3, write_reg_addr3, write_data3,
           pc_write_enable, pc_write_data, mem_addr, mem_write_enable,
           mem_write_data, busy, done
  );

  modport slave (
    input  start, is_load, pre_index, up, writeback, base_reg, base_value,
           register_list, read_data2, mem_read_data,
    output read_reg_addr2, write_enable3, write_reg_addr3, write_data3,
           pc_write_enable, pc_write_data, mem_addr, mem_write_enable,
           mem_write_data, busy, done
  );
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit in a register list.
module lowest_set_bit_encoder #(
  parameter int unsigned REG_COUNT = 16
) (
  input  logic [REG_COUNT-1:0]         list,
  output logic [$clog2(REG_COUNT)-1:0] index,
  output logic                         valid
);
  localparam int unsigned IDX_W = $clog2(REG_COUNT);

  // Scan downward so the lowest set bit is the last one to claim the index.
  always_comb begin
    index = '0;
    for (int i = int'(REG_COUNT) - 1; i >= 0; i--) begin
      if (list[i]) index = IDX_W'(i);
    end
  end

  assign valid = |list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one register per cycle, then optional base writeback.
module ldm_stm_sequencer
  import arm_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16
) (
  input logic                clk,
  input logic                reset,
  ldm_stm_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(REG_COUNT);
  localparam int unsigned CNT_W = $clog2(REG_COUNT + 1);

  ldm_state_t            state_q, state_d;
  logic [REG_COUNT-1:0]  list_q, list_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] final_q, final_d;
  logic                  is_load_q, is_load_d;
  logic                  wb_q, wb_d;
  logic [IDX_W-1:0]      base_reg_q, base_reg_d;

  logic [CNT_W-1:0]      n_c;
  logic [DATA_WIDTH-1:0] span_c;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_valid;

  lowest_set_bit_encoder #(.REG_COUNT(REG_COUNT)) u_lsb (
    .list  (list_q),
    .index (cur_idx),
    .valid (cur_valid)
  );

  always_comb begin
    n_c = '0;
    for (int i = 0; i < int'(REG_COUNT); i++) n_c = n_c + CNT_W'(bus.register_list[i]);
    span_c = DATA_WIDTH'(n_c) * DATA_WIDTH'(WORD_BYTES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      is_load_q  <= 1'b0;
      wb_q       <= 1'b0;
      base_reg_q <= '0;
    end else begin
      list_q     <= list_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      is_load_q  <= is_load_d;
      wb_q       <= wb_d;
      base_reg_q <= base_reg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    final_d    = final_q;
    is_load_d  = is_load_q;
    wb_d       = wb_q;
    base_reg_d = base_reg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          list_d     = bus.register_list;
          is_load_d  = bus.is_load;
          base_reg_d = bus.base_reg;
          // A load that overwrites the base register wins over writeback.
          wb_d       = bus.writeback & ~(bus.is_load & bus.register_list[bus.base_reg]);
          final_d    = bus.up ? bus.base_value + span_c : bus.base_value - span_c;
          case ({bus.pre_index, bus.up})
            2'b01:   addr_d = bus.base_value;
            2'b11:   addr_d = bus.base_value + DATA_WIDTH'(WORD_BYTES);
            2'b00:   addr_d = bus.base_value - span_c + DATA_WIDTH'(WORD_BYTES);
            default: addr_d = bus.base_value - span_c;
          endcase
          state_d = (n_c == '0) ? S_DONE : S_TRANSFER;
        end
      end
      S_TRANSFER: begin
        list_d = list_q & ~(REG_COUNT'(1) << cur_idx);
        addr_d = addr_q + DATA_WIDTH'(WORD_BYTES);
        if (list_d == '0 || !cur_valid) state_d = wb_q ? S_WRITEBACK : S_DONE;
      end
      S_WRITEBACK: state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
  end

  logic [IDX_W-1:0]      read_reg_addr2_c;
  logic                  write_enable3_c;
  logic [IDX_W-1:0]      write_reg_addr3_c;
  logic [DATA_WIDTH-1:0] write_data3_c;
  logic                  pc_write_enable_c;
  logic [DATA_WIDTH-1:0] pc_write_data_c;
  logic [DATA_WIDTH-1:0] mem_addr_c;
  logic                  mem_write_enable_c;
  logic [DATA_WIDTH-1:0] mem_write_data_c;
  logic                  done_c;

  // Outputs decode from registered state; load/store data pass straight through.
  always_comb begin
    read_reg_addr2_c   = '0;
    write_enable3_c    = 1'b0;
    write_reg_addr3_c  = '0;
    write_data3_c      = '0;
    pc_write_enable_c  = 1'b0;
    pc_write_data_c    = '0;
    mem_addr_c         = '0;
    mem_write_enable_c = 1'b0;
    mem_write_data_c   = '0;
    done_c             = 1'b0;
    case (state_q)
      S_TRANSFER: begin
        if (cur_valid) begin
          mem_addr_c = addr_q;
          if (!is_load_q) begin
            read_reg_addr2_c   = cur_idx;
            mem_write_data_c   = bus.read_data2;
            mem_write_enable_c = 1'b1;
          end else if (cur_idx == IDX_W'(PC_INDEX)) begin
            pc_write_enable_c = 1'b1;
            pc_write_data_c   = bus.mem_read_data;
          end else begin
            write_enable3_c   = 1'b1;
            write_reg_addr3_c = cur_idx;
            write_data3_c     = bus.mem_read_data;
          end
        end
      end
      S_WRITEBACK: begin
        write_enable3_c   = 1'b1;
        write_reg_addr3_c = base_reg_q;
        write_data3_c     = final_q;
      end
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.read_reg_addr2   = read_reg_addr2_c;
  assign bus.write_enable3    = write_enable3_c;
  assign bus.write_reg_addr3  = write_reg_addr3_c;
  assign bus.write_data3      = write_data3_c;
  assign bus.pc_write_enable  = pc_write_enable_c;
  assign bus.pc_write_data    = pc_write_data_c;
  assign bus.mem_addr         = mem_addr_c;
  assign bus.mem_write_enable = mem_write_enable_c;
  assign bus.mem_write_data   = mem_write_data_c;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.done             = done_c;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed LDM/STM cases with hand-computed addresses.
module tb_ldm_stm_sequencer;

  typedef struct packed {
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  rra2;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_r = 1'b0, is_load_r = 1'b0, pre_r = 1'b0, up_r = 1'b0, wb_r = 1'b0;
  logic [3:0]  base_reg_r = '0;
  logic [31:0] base_value_r = '0;
  logic [15:0] list_r = '0;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  ldm_stm_sequencer_if #(.DATA_WIDTH(32), .REG_COUNT(16)) bus ();

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return 32'hC0DE_0000 | 32'(r);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return ~a;
  endfunction

  assign bus.start         = start_r;
  assign bus.is_load       = is_load_r;
  assign bus.pre_index     = pre_r;
  assign bus.up            = up_r;
  assign bus.writeback     = wb_r;
  assign bus.base_reg      = base_reg_r;
  assign bus.base_value    = base_value_r;
  assign bus.register_list = list_r;
  assign bus.read_data2    = rf_val(bus.read_reg_addr2);
  assign bus.mem_read_data = mem_val(bus.mem_addr);

  ldm_stm_sequencer #(.DATA_WIDTH(32), .REG_COUNT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.mem_addr  = bus.mem_addr;
    o.mem_we    = bus.mem_write_enable;
    o.mem_wdata = bus.mem_write_data;
    o.rra2      = bus.read_reg_addr2;
    o.we3       = bus.write_enable3;
    o.wa3       = bus.write_reg_addr3;
    o.wd3       = bus.write_data3;
    o.pc_we     = bus.pc_write_enable;
    o.pc_wd     = bus.pc_write_data;
    o.done      = bus.done;
    return o;
  endfunction

  function automatic obs_t e_st(input logic [31:0] a, input logic [3:0] r);
    obs_t o = '0;
    o.mem_addr = a; o.mem_we = 1'b1; o.mem_wdata = rf_val(r); o.rra2 = r;
    return o;
  endfunction

  function automatic obs_t e_ld(input logic [31:0] a, input logic [3:0] r);
    obs_t o = '0;
    o.mem_addr = a;
    if (r == 4'd15) begin o.pc_we = 1'b1; o.pc_wd = mem_val(a); end
    else begin o.we3 = 1'b1; o.wa3 = r; o.wd3 = mem_val(a); end
    return o;
  endfunction

  function automatic obs_t e_wb(input logic [3:0] r, input logic [31:0] v);
    obs_t o = '0;
    o.we3 = 1'b1; o.wa3 = r; o.wd3 = v;
    return o;
  endfunction

  function automatic obs_t e_dn();
    obs_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe or done pulse must match the next queued expectation.
  always @(negedge clk) begin
    obs_t cur, e;
    if (!reset) begin
      cur = sample();
      if (cur.mem_we || cur.we3 || cur.pc_we || cur.done) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got %h, expected nothing", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL sb_output: got %h, expected %h", cur, e);
          end
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic p, input logic u, input logic w,
                       input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst);
    is_load_r = ld; pre_r = p; up_r = u; wb_r = w;
    base_reg_r = br; base_value_r = bv; list_r = lst; start_r = 1'b1;
  endtask

  task automatic run_op(input string name, input logic ld, input logic p, input logic u,
                        input logic w, input logic [3:0] br, input logic [31:0] bv,
                        input logic [15:0] lst, input int exp_cycles, input bit poke);
    int cycles = 0;
    bit got = 1'b0;
    @(negedge clk);
    drive(ld, p, u, w, br, bv, lst);
    @(posedge clk);
    #1 start_r = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check({name, "_busy"}, 64'(bus.busy), 64'd1);
      if (poke && cycles == 1) begin
        start_r = 1'b1; list_r = 16'hFFFF; is_load_r = ~ld; base_value_r = 32'hDEAD_0000;
      end else if (poke && cycles == 2) begin
        start_r = 1'b0;
      end
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else begin
      check({name, "_latency"}, 64'(cycles), 64'(exp_cycles));
    end
    @(negedge clk);
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({bus.busy, sample()} != '0), 64'd0);
    reset = 1'b0;

    // Reset during the second transfer of an LDM IA of 0x00FF.
    exp_q.push_back(e_ld(32'h1000, 4'd0));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h1000, 16'h00FF);
    @(posedge clk);
    #1 start_r = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_outputs", 64'(sample() != '0), 64'd0);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midreset_drain", 64'(exp_q.size()), 64'd0);

    exp_q.push_back(e_ld(32'h40, 4'd0));
    exp_q.push_back(e_ld(32'h44, 4'd1));
    exp_q.push_back(e_dn());
    run_op("after_reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 32'h40, 16'h0003, 3, 1'b0);

    // STM IA with writeback, plus an ignored start while busy.
    exp_q.push_back(e_st(32'h100, 4'd0));
    exp_q.push_back(e_st(32'h104, 4'd2));
    exp_q.push_back(e_wb(4'd13, 32'h108));
    exp_q.push_back(e_dn());
    run_op("stm_ia", 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h0005, 4, 1'b1);

    exp_q.push_back(e_ld(32'h1F4, 4'd0));
    exp_q.push_back(e_ld(32'h1F8, 4'd1));
    exp_q.push_back(e_ld(32'h1FC, 4'd15));
    exp_q.push_back(e_wb(4'd4, 32'h1F4));
    exp_q.push_back(e_dn());
    run_op("ldm_db_pc", 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h200, 16'h8003, 5, 1'b0);

    // Base register loaded from memory: writeback suppressed.
    exp_q.push_back(e_ld(32'h304, 4'd1));
    exp_q.push_back(e_ld(32'h308, 4'd2));
    exp_q.push_back(e_dn());
    run_op("ldm_ib_nowb", 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0006, 3, 1'b0);

    exp_q.push_back(e_dn());
    run_op("empty_list", 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h500, 16'h0000, 1, 1'b0);

    exp_q.push_back(e_st(32'hFFFF_FFFC, 4'd0));
    exp_q.push_back(e_st(32'h0000_0000, 4'd1));
    exp_q.push_back(e_st(32'h0000_0004, 4'd2));
    exp_q.push_back(e_wb(4'd9, 32'hFFFF_FFF8));
    exp_q.push_back(e_dn());
    run_op("stm_da_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'h4, 16'h0007, 5, 1'b0);

    // STM keeps writeback even when the base register is in the list.
    exp_q.push_back(e_st(32'h78, 4'd1));
    exp_q.push_back(e_st(32'h7C, 4'd4));
    exp_q.push_back(e_wb(4'd1, 32'h78));
    exp_q.push_back(e_dn());
    run_op("stm_db_base", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h80, 16'h0012, 4, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
